// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the raster generator: enable/pattern controls in, request/coordinates and video out.
// master is the generator side; slave is the frame source / DAC side.
interface vga_timing_gen_if #(
  parameter int CW = 3,
  parameter int XW = 10,
  parameter int YW = 10
);
  logic            en;
  logic [1:0]      mode;
  logic [3*CW-1:0] solid_rgb;
  logic [3*CW-1:0] ext_rgb;
  logic            pix_req;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;
  logic            hsync;
  logic            vsync;
  logic            de;
  logic [CW-1:0]   red;
  logic [CW-1:0]   green;
  logic [CW-1:0]   blue;
  logic            frame_start;
  logic            line_start;

  modport master (
    input  en, mode, solid_rgb, ext_rgb,
    output pix_req, pix_x, pix_y, hsync, vsync, de, red, green, blue, frame_start, line_start
  );

  modport slave (
    output en, mode, solid_rgb, ext_rgb,
    input  pix_req, pix_x, pix_y, hsync, vsync, de, red, green, blue, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with pattern source; video outputs lag pix_req/pix_x/pix_y by one enabled cycle.
// en=0 stalls counters and freezes every registered output; there is no other backpressure.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 3
) (
  input  logic             dclk,
  input  logic             clr,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  logic [XW-1:0] hc;
  logic [YW-1:0] vc;
  logic [XW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_q;
  logic [1:0]    mode_eff;

  logic h_act, v_act, active, origin, h_last, v_last, hs_win, vs_win;
  logic chk_h, chk_v;
  logic [CW-1:0] pr, pg, pb;

  logic          hsync_q, vsync_q, de_q, fs_q, ls_q;
  logic [CW-1:0] red_q, green_q, blue_q;

  assign h_act  = int'(hc) < H_ACTIVE;
  assign v_act  = int'(vc) < V_ACTIVE;
  assign active = h_act & v_act;
  assign origin = (hc == '0) && (vc == '0);
  assign h_last = int'(hc) == H_TOTAL - 1;
  assign v_last = int'(vc) == V_TOTAL - 1;
  assign hs_win = (int'(hc) >= HS_BEG) && (int'(hc) < HS_END);
  assign vs_win = (int'(vc) >= VS_BEG) && (int'(vc) < VS_END);

  // A new mode applies from the very pixel it is sampled on.
  assign mode_eff = origin ? vif.mode : mode_q;

  if (XW > 5) begin : g_chk_h
    assign chk_h = hc[5];
  end else begin : g_nchk_h
    assign chk_h = 1'b0;
  end

  if (YW > 5) begin : g_chk_v
    assign chk_v = vc[5];
  end else begin : g_nchk_v
    assign chk_v = 1'b0;
  end

  always_comb begin
    pr = '0;
    pg = '0;
    pb = '0;
    case (mode_eff)
      2'd0: begin
        // Bar order white..black maps to RGB = ~{idx[1], idx[2], idx[0]}.
        pr = {CW{~bar_idx[1]}};
        pg = {CW{~bar_idx[2]}};
        pb = {CW{~bar_idx[0]}};
      end
      2'd1:    {pr, pg, pb} = {(3*CW){~(chk_h ^ chk_v)}};
      2'd2:    {pr, pg, pb} = vif.solid_rgb;
      default: {pr, pg, pb} = vif.ext_rgb;
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      hc      <= '0;
      vc      <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
      mode_q  <= '0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (vif.en) begin
      hsync_q <= hs_win ? HS_POL : ~HS_POL;
      vsync_q <= vs_win ? VS_POL : ~VS_POL;
      de_q    <= active;
      {red_q, green_q, blue_q} <= active ? {pr, pg, pb} : '0;
      fs_q    <= origin;
      ls_q    <= (hc == '0) && v_act;
      if (origin) begin
        mode_q <= vif.mode;
      end
      if (h_last) begin
        hc      <= '0;
        bar_px  <= '0;
        bar_idx <= '0;
        vc      <= v_last ? '0 : vc + YW'(1);
      end else begin
        hc <= hc + XW'(1);
        // Last bar absorbs any remainder pixels and the blanking interval.
        if ((int'(bar_px) == BAR_W - 1) && (bar_idx != 3'd7)) begin
          bar_px  <= '0;
          bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_px <= bar_px + XW'(1);
        end
      end
    end
  end

  assign vif.pix_req     = vif.en & active;
  assign vif.pix_x       = hc;
  assign vif.pix_y       = vc;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.de          = de_q;
  assign vif.red         = red_q;
  assign vif.green       = green_q;
  assign vif.blue        = blue_q;
  assign vif.frame_start = fs_q;
  assign vif.line_start  = ls_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 800x521 instance for line-level checks and a 14x7 instance for whole-frame checks.
module tb_vga_timing_gen;
  logic dclk = 1'b0;
  logic clr_d;
  logic clr_s;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   fs_cyc [4];
  int   nfs   = 0;

  logic [8:0] bars [8] = '{9'o777, 9'o770, 9'o077, 9'o070, 9'o707, 9'o700, 9'o007, 9'o000};

  always #5 dclk = ~dclk;
  always @(posedge dclk) cyc++;

  vga_timing_gen_if #(.CW(3), .XW(10), .YW(10)) dv ();
  vga_timing_gen_if #(.CW(3), .XW(4),  .YW(3))  sv ();

  assign sv.ext_rgb = {sv.pix_x[2:0], 3'd2, 3'd5};

  vga_timing_gen dut_d (
    .dclk (dclk),
    .clr  (clr_d),
    .vif  (dv.master)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(3)
  ) dut_s (
    .dclk (dclk),
    .clr  (clr_s),
    .vif  (sv.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  initial begin
    clr_d = 1'b1;
    clr_s = 1'b1;
    dv.en = 1'b1; dv.mode = 2'd0; dv.solid_rgb = '0; dv.ext_rgb = '0;
    sv.en = 1'b1; sv.mode = 2'd0; sv.solid_rgb = 9'o543;
    adv(3);

    chk("rst_hs",   dv.hsync, 1);
    chk("rst_vs",   dv.vsync, 1);
    chk("rst_de",   dv.de, 0);
    chk("rst_rgb",  {dv.red, dv.green, dv.blue}, 0);
    chk("rst_fs",   dv.frame_start, 0);
    chk("rst_ls",   dv.line_start, 0);
    chk("rst_x",    dv.pix_x, 0);
    chk("s_rst_hs", sv.hsync, 0);
    chk("s_rst_vs", sv.vsync, 1);

    clr_d = 1'b0;
    chk("req0", dv.pix_req, 1);
    tick();
    chk("p0_fs",  dv.frame_start, 1);
    chk("p0_ls",  dv.line_start, 1);
    chk("p0_de",  dv.de, 1);
    chk("p0_rgb", {dv.red, dv.green, dv.blue}, 9'o777);
    chk("p0_x",   dv.pix_x, 1);
    adv(79);
    chk("x79_rgb", {dv.red, dv.green, dv.blue}, 9'o777);
    chk("x79_ls",  dv.line_start, 0);
    adv(1);
    chk("x80_rgb", {dv.red, dv.green, dv.blue}, 9'o770);
    adv(80);
    chk("x160_rgb", {dv.red, dv.green, dv.blue}, 9'o077);
    adv(139);
    chk("x299_rgb", {dv.red, dv.green, dv.blue}, 9'o070);
    chk("x300_pos", dv.pix_x, 300);

    // Ten-cycle stall while pixel 300 is pending.
    dv.en = 1'b0;
    #1;
    chk("stall_req", dv.pix_req, 0);
    adv(10);
    chk("stall_x",   dv.pix_x, 300);
    chk("stall_rgb", {dv.red, dv.green, dv.blue}, 9'o070);
    chk("stall_de",  dv.de, 1);
    chk("stall_req2", dv.pix_req, 0);
    dv.en = 1'b1;
    #1;
    chk("resume_req", dv.pix_req, 1);
    tick();
    chk("resume_x", dv.pix_x, 301);

    adv(339);
    chk("x639_rgb", {dv.red, dv.green, dv.blue}, 9'o000);
    chk("x639_de",  dv.de, 1);
    adv(1);
    chk("x640_de",  dv.de, 0);
    chk("x640_rgb", {dv.red, dv.green, dv.blue}, 0);
    adv(15);
    chk("x655_hs", dv.hsync, 1);
    adv(1);
    chk("x656_hs", dv.hsync, 0);
    adv(95);
    chk("x751_hs", dv.hsync, 0);
    adv(1);
    chk("x752_hs", dv.hsync, 1);
    adv(47);
    chk("x799_de", dv.de, 0);
    chk("x799_vs", dv.vsync, 1);
    adv(1);
    chk("y1_ls",  dv.line_start, 1);
    chk("y1_fs",  dv.frame_start, 0);
    chk("y1_de",  dv.de, 1);
    chk("y1_y",   dv.pix_y, 1);
    chk("y1_rgb", {dv.red, dv.green, dv.blue}, 9'o777);

    // Asynchronous clear mid-line, then restart in checkerboard mode.
    adv(5);
    clr_d = 1'b1;
    #1;
    chk("aclr_de",  dv.de, 0);
    chk("aclr_rgb", {dv.red, dv.green, dv.blue}, 0);
    chk("aclr_hs",  dv.hsync, 1);
    chk("aclr_x",   dv.pix_x, 0);
    chk("aclr_y",   dv.pix_y, 0);
    dv.mode = 2'd1;
    tick();
    clr_d = 1'b0;
    tick();
    chk("ck0_fs",  dv.frame_start, 1);
    chk("ck0_rgb", {dv.red, dv.green, dv.blue}, 9'o777);
    adv(31);
    chk("ck31_rgb", {dv.red, dv.green, dv.blue}, 9'o777);
    adv(1);
    chk("ck32_rgb", {dv.red, dv.green, dv.blue}, 9'o000);
    chk("ck32_de",  dv.de, 1);

    // Small instance: bars in frame 0, solid in frame 1, external in frame 2 with a 5-cycle stall.
    for (int i = 0; i < 4; i++) fs_cyc[i] = -1;
    clr_s = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int y = 0; y < 7; y++) begin
        for (int x = 0; x < 14; x++) begin
          logic       act;
          logic [8:0] erg;
          if (f == 0 && y == 0 && x == 1) sv.mode = 2'd2;
          if (f == 1 && y == 3 && x == 5) sv.mode = 2'd3;
          if (f == 2 && y == 2 && x == 3) begin
            sv.en = 1'b0;
            #1;
            chk("s_stall_req", sv.pix_req, 0);
            adv(5);
            chk("s_stall_x",   sv.pix_x, 3);
            chk("s_stall_red", sv.red, 2);
            chk("s_stall_de",  sv.de, 1);
            sv.en = 1'b1;
            #1;
          end
          act = (x < 8) && (y < 4);
          chk($sformatf("s_req f%0d y%0d x%0d", f, y, x), sv.pix_req, act);
          chk($sformatf("s_x f%0d y%0d x%0d", f, y, x), sv.pix_x, x);
          chk($sformatf("s_y f%0d y%0d x%0d", f, y, x), sv.pix_y, y);
          tick();
          if (sv.frame_start === 1'b1 && nfs < 4) begin
            fs_cyc[nfs] = cyc;
            nfs++;
          end
          if (!act)        erg = 9'o000;
          else if (f == 0) erg = bars[x];
          else if (f == 1) erg = 9'o543;
          else             erg = {3'(x), 3'd2, 3'd5};
          chk($sformatf("s_de f%0d y%0d x%0d", f, y, x), sv.de, act);
          chk($sformatf("s_hs f%0d y%0d x%0d", f, y, x), sv.hsync, (x == 10 || x == 11));
          chk($sformatf("s_vs f%0d y%0d x%0d", f, y, x), sv.vsync, (y != 5));
          chk($sformatf("s_fs f%0d y%0d x%0d", f, y, x), sv.frame_start, (x == 0 && y == 0));
          chk($sformatf("s_ls f%0d y%0d x%0d", f, y, x), sv.line_start, (x == 0 && y < 4));
          chk($sformatf("s_rgb f%0d y%0d x%0d", f, y, x), {sv.red, sv.green, sv.blue}, erg);
        end
      end
    end
    tick();
    if (sv.frame_start === 1'b1 && nfs < 4) begin
      fs_cyc[nfs] = cyc;
      nfs++;
    end
    chk("s_f3_fs",  sv.frame_start, 1);
    chk("s_nfs",    nfs, 4);
    chk("s_per01",  fs_cyc[1] - fs_cyc[0], 98);
    chk("s_per12",  fs_cyc[2] - fs_cyc[1], 98);
    chk("s_per23",  fs_cyc[3] - fs_cyc[2], 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/DVI raster timing generator with an integrated pattern source.
- Successor to the fixed 640x480 colour-bar generator.
- All porch/sync/active lengths, sync polarities and colour width are parameters.
- Adds a pixel-clock enable, pixel-request/coordinate interface for an external frame source, a data-enable output, frame/line start pulses, and a runtime-selectable pattern mode. It sits between the pixel-clock domain and the video DAC/encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- CW, 3, bits per colour channel

Ports:
- dclk  in  1  pixel clock
- clr  in  1  reset, asynchronous, active-high
- en  in  1  pixel enable; low stalls the whole block
- mode  in  2  pattern: 0 colour bars, 1 checkerboard, 2 solid, 3 external
- solid_rgb  in  3*CW  solid colour {r,g,b}
- ext_rgb  in  3*CW  external pixel {r,g,b}, valid in the cycle pix_req=1
- pix_req  out  1  combinational: current counter position is active and en=1
- pix_x  out  clog2(H_TOTAL)  current horizontal counter
- pix_y  out  clog2(V_TOTAL)  current vertical counter
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- de  out  1  registered data enable
- red, green, blue  out  CW each  registered colour
- frame_start  out  1  one-cycle pulse coincident with first de of a frame
- line_start  out  1  one-cycle pulse coincident with first de of each active line

Behaviour:
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 521).
  - Counter widths are clog2 of the totals.
- Counter origin is the first active pixel.
  - hc 0..H_ACTIVE-1 active; then FP, then sync hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then BP. Same layout for vc.
- Counting occurs only on dclk edges with en=1:
  - hc wraps at H_TOTAL-1 to 0 and increments vc.
  - vc wraps at V_TOTAL-1 to 0.
- Output stage (hsync, vsync, de, rgb, frame_start, line_start) is registered, loads only when en=1, and reflects the counter state of the same edge.
  - Latency from pix_req/pix_x/pix_y/ext_rgb to output is exactly 1 enabled cycle.
- en=0: counters and all registered outputs hold. pix_req is forced to 0.
- Sync levels:
  - hsync = HS_POL inside the sync window, else ~HS_POL.
  - vsync = VS_POL inside the sync window, else ~VS_POL.
  - vsync transitions are aligned to hc=0.
- Blanking: de=0 and rgb=0 outside the active region, regardless of mode.
- Mode register:
  - mode is sampled into an internal register only at (hc,vc)=(0,0) with en=1, and takes effect from that pixel.
  - Changes mid-frame are ignored until the next frame.
- Colour bars:
  - 8 bars, each H_ACTIVE/8 pixels wide, left to right: white, yellow, cyan, green, magenta, red, blue, black.
  - "Full" means all CW bits set.
  - The bar index comes from a bar counter reset at hc=0, not a divider.
  - H_ACTIVE must be a multiple of 8; any remainder pixels take the last bar.
- Checkerboard: white where hc[5]^vc[5]=0, black otherwise (32x32 squares).
- Solid: solid_rgb. External: ext_rgb as presented with pix_req.
- Pulses:
  - frame_start=1 for the output cycle of pixel (0,0).
  - line_start=1 for the output cycle of pixel (0,y) for y<V_ACTIVE.
  - Both are otherwise 0.
- Reset (clr=1, any time, asynchronously):
  - hc=vc=0, mode register=0.
  - hsync=~HS_POL, vsync=~VS_POL, de=0, rgb=0, frame_start=line_start=0.
  - After release, the first enabled edge outputs pixel (0,0) with frame_start=1.

Test Plan:
- Reset release, en=1, mode=0, defaults -> 1st edge: de=1, frame_start=1, line_start=1, rgb=7/7/7; hsync=vsync=1 during reset.
- Free-run 2 frames -> frame_start period 416800 cycles; 640 de cycles per line, 307200 per frame; hsync=0 for 96 cycles starting 656 cycles after each line_start; vsync=0 for 1600 cycles starting 490 lines after frame_start.
- Colour bars -> x=79 rgb 7/7/7, x=80 7/7/0, x=160 0/7/7, x=639 0/0/0, x=640 de=0 rgb 0.
- Mode 0->2 written at x=100,y=200 -> bars continue to frame end; solid_rgb appears from the next frame_start. Clr asserted mid-line -> outputs reset immediately.
- en low 10 cycles mid-line at x=300 -> all outputs frozen, pix_req=0; resume at x=300; frame period becomes 416810.
- Override H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, HS_POL=1, mode=3, ext_rgb driven from pix_x -> 14-cycle lines, hsync high 2 cycles after x=9; red lags pix_x by 1 cycle; 7-line frames.
